// File: rtl/tmds_link_sequencer_if.sv
// Link-sequencer signal bundle: lock/enable/frame controls, TMDS symbol paths, status.
interface tmds_link_sequencer_if;
  logic       i_mmcm_locked;
  logic       i_enable;
  logic       i_frame_start;
  logic [9:0] i_tmds_ch0;
  logic [9:0] i_tmds_ch1;
  logic [9:0] i_tmds_ch2;
  logic [9:0] o_tmds_ch0;
  logic [9:0] o_tmds_ch1;
  logic [9:0] o_tmds_ch2;
  logic       o_rst_oserdes;
  logic       o_link_up;
  logic [2:0] o_state;

  // Driver side: timing generator, encoders and MMCM feed the sequencer.
  modport master (
    output i_mmcm_locked, i_enable, i_frame_start,
    output i_tmds_ch0, i_tmds_ch1, i_tmds_ch2,
    input  o_tmds_ch0, o_tmds_ch1, o_tmds_ch2,
    input  o_rst_oserdes, o_link_up, o_state
  );

  // Sequencer side.
  modport slave (
    input  i_mmcm_locked, i_enable, i_frame_start,
    input  i_tmds_ch0, i_tmds_ch1, i_tmds_ch2,
    output o_tmds_ch0, o_tmds_ch1, o_tmds_ch2,
    output o_rst_oserdes, o_link_up, o_state
  );
endinterface

// File: rtl/tmds_link_sequencer.sv
// TMDS transmit link bring-up: waits for stable MMCM lock, sequences serializer
// reset, sends control tokens, and switches to video on a frame boundary.
module tmds_link_sequencer #(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned RST_CYCLES         = 16,
  parameter int unsigned SYNC_MIN_CYCLES    = 64,
  parameter logic [9:0]  CTRL_TOKEN         = 10'b1101010100
) (
  input logic                  pix_1x_clk,
  input logic                  i_rst,
  tmds_link_sequencer_if.slave link
);

  localparam int unsigned MAX_AB  = (LOCK_STABLE_CYCLES > RST_CYCLES) ? LOCK_STABLE_CYCLES : RST_CYCLES;
  localparam int unsigned MAX_CNT = (MAX_AB > SYNC_MIN_CYCLES) ? MAX_AB : SYNC_MIN_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SYNC_SAT  = CNT_W'(SYNC_MIN_CYCLES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LOCK = 3'd1,
    RST_HOLD  = 3'd2,
    SYNC      = 3'd3,
    ACTIVE    = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lock_meta, lock_s;
  logic             rst_oserdes_q, rst_oserdes_nxt;
  logic             link_up_q, link_up_nxt;
  logic [9:0]       tmds0_q, tmds1_q, tmds2_q;
  logic [9:0]       tmds0_nxt, tmds1_nxt, tmds2_nxt;

  // Two-flop synchronizer for the asynchronous MMCM lock.
  always_ff @(posedge pix_1x_clk) begin
    if (i_rst) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= link.i_mmcm_locked;
      lock_s    <= lock_meta;
    end
  end

  // State, shared counter and output registers.
  always_ff @(posedge pix_1x_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      cnt           <= '0;
      rst_oserdes_q <= 1'b1;
      link_up_q     <= 1'b0;
      tmds0_q       <= CTRL_TOKEN;
      tmds1_q       <= CTRL_TOKEN;
      tmds2_q       <= CTRL_TOKEN;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      rst_oserdes_q <= rst_oserdes_nxt;
      link_up_q     <= link_up_nxt;
      tmds0_q       <= tmds0_nxt;
      tmds1_q       <= tmds1_nxt;
      tmds2_q       <= tmds2_nxt;
    end
  end

  // Next state and counter; disable beats lock loss, lock loss beats per-state rules.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!link.i_enable && (state != IDLE)) begin
      state_nxt = IDLE;
    end else if (!lock_s && ((state == RST_HOLD) || (state == SYNC) || (state == ACTIVE))) begin
      state_nxt = WAIT_LOCK;
    end else begin
      case (state)
        IDLE: begin
          if (link.i_enable) state_nxt = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (!lock_s)                cnt_nxt   = '0;
          else if (cnt == LOCK_LAST)  state_nxt = RST_HOLD;
          else                        cnt_nxt   = cnt + CNT_W'(1);
        end
        RST_HOLD: begin
          if (cnt == RST_LAST) state_nxt = SYNC;
          else                 cnt_nxt   = cnt + CNT_W'(1);
        end
        SYNC: begin
          if (cnt == SYNC_SAT) begin
            if (link.i_frame_start) state_nxt = ACTIVE;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        ACTIVE: begin
          state_nxt = ACTIVE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
    if (state_nxt != state) cnt_nxt = '0;
  end

  // Outputs decoded from the next state so they change on entry.
  always_comb begin
    rst_oserdes_nxt = 1'b1;
    link_up_nxt     = 1'b0;
    tmds0_nxt       = CTRL_TOKEN;
    tmds1_nxt       = CTRL_TOKEN;
    tmds2_nxt       = CTRL_TOKEN;
    if ((state_nxt == SYNC) || (state_nxt == ACTIVE)) rst_oserdes_nxt = 1'b0;
    if (state_nxt == ACTIVE) begin
      link_up_nxt = 1'b1;
      tmds0_nxt   = link.i_tmds_ch0;
      tmds1_nxt   = link.i_tmds_ch1;
      tmds2_nxt   = link.i_tmds_ch2;
    end
  end

  assign link.o_state       = state;
  assign link.o_rst_oserdes = rst_oserdes_q;
  assign link.o_link_up     = link_up_q;
  assign link.o_tmds_ch0    = tmds0_q;
  assign link.o_tmds_ch1    = tmds1_q;
  assign link.o_tmds_ch2    = tmds2_q;

endmodule

// File: tb/tb_tmds_link_sequencer.sv
// Directed bench for tmds_link_sequencer: vector table plus hand-written bring-up timing.
module tb_tmds_link_sequencer;

  localparam logic [9:0] TOKEN = 10'h354;

  typedef struct {
    int         n;
    logic       rst;
    logic       en;
    logic       lock;
    logic       fs;
    logic [2:0] st;
    logic       ro;
    logic       lu;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   tests  = 0;
  int   failed = 0;
  int   pat    = 0;
  logic [9:0] p0, p1, p2;
  vec_t vq[$];

  tmds_link_sequencer_if lif ();

  tmds_link_sequencer #(
    .LOCK_STABLE_CYCLES(8),
    .RST_CYCLES        (4),
    .SYNC_MIN_CYCLES   (6),
    .CTRL_TOKEN        (10'b1101010100)
  ) dut (
    .pix_1x_clk(clk),
    .i_rst     (rst),
    .link      (lif.slave)
  );

  always #5 clk = ~clk;

  // Changing encoder symbols each cycle.
  always @(negedge clk) begin
    pat = pat + 1;
    lif.i_tmds_ch0 = 10'(pat * 7 + 1);
    lif.i_tmds_ch1 = 10'(pat * 13 + 5);
    lif.i_tmds_ch2 = 10'(pat * 29 + 11);
  end

  // Symbols the DUT saw at the last edge.
  always @(posedge clk) begin
    p0 <= lif.i_tmds_ch0;
    p1 <= lif.i_tmds_ch1;
    p2 <= lif.i_tmds_ch2;
  end

  function automatic void add(input int n, input logic r, input logic en, input logic lk,
                              input logic fs, input logic [2:0] st, input logic ro, input logic lu);
    vec_t v;
    v.n = n; v.rst = r; v.en = en; v.lock = lk; v.fs = fs;
    v.st = st; v.ro = ro; v.lu = lu;
    vq.push_back(v);
  endfunction

  task automatic cmp(input string name, input int idx, input logic [9:0] act, input logic [9:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic check(input int idx, input logic [2:0] st, input logic ro, input logic lu);
    cmp("state", idx, 10'(lif.o_state), 10'(st));
    cmp("rst_oserdes", idx, 10'(lif.o_rst_oserdes), 10'(ro));
    cmp("link_up", idx, 10'(lif.o_link_up), 10'(lu));
    cmp("tmds_ch0", idx, lif.o_tmds_ch0, (st == 3'd4) ? p0 : TOKEN);
    cmp("tmds_ch1", idx, lif.o_tmds_ch1, (st == 3'd4) ? p1 : TOKEN);
    cmp("tmds_ch2", idx, lif.o_tmds_ch2, (st == 3'd4) ? p2 : TOKEN);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int edges;
    rst = 1'b1;
    lif.i_enable = 1'b0;
    lif.i_mmcm_locked = 1'b0;
    lif.i_frame_start = 1'b0;
    lif.i_tmds_ch0 = '0;
    lif.i_tmds_ch1 = '0;
    lif.i_tmds_ch2 = '0;

    //   n  rst en lk fs  st ro lu
    add(3, 1, 0, 0, 0, 0, 1, 0);   // reset state
    add(1, 0, 1, 0, 0, 1, 1, 0);   // enable -> WAIT_LOCK
    add(5, 0, 1, 0, 0, 1, 1, 0);   // no lock, stays
    add(8, 0, 1, 1, 0, 1, 1, 0);   // lock raised; still counting
    add(1, 0, 1, 1, 0, 1, 1, 0);   // cnt reaches 7
    add(1, 0, 1, 1, 0, 2, 1, 0);   // RST_HOLD
    add(3, 0, 1, 1, 0, 2, 1, 0);
    add(1, 0, 1, 1, 0, 3, 0, 0);   // SYNC, serializer reset released
    add(3, 0, 1, 1, 0, 3, 0, 0);
    add(1, 0, 1, 1, 1, 3, 0, 0);   // frame at cnt=3 ignored
    add(1, 0, 1, 1, 0, 3, 0, 0);
    add(1, 0, 1, 1, 1, 3, 0, 0);   // frame at cnt=5 ignored
    add(1, 0, 1, 1, 1, 4, 0, 1);   // frame at saturation accepted
    add(5, 0, 1, 1, 0, 4, 0, 1);   // video tracking
    add(2, 0, 1, 0, 0, 4, 0, 1);   // lock drop still in synchronizer
    add(1, 0, 1, 0, 0, 1, 1, 0);   // lock loss -> WAIT_LOCK
    add(3, 0, 1, 0, 0, 1, 1, 0);
    add(9, 0, 1, 1, 0, 1, 1, 0);   // recovery
    add(1, 0, 1, 1, 0, 2, 1, 0);
    add(3, 0, 1, 1, 0, 2, 1, 0);
    add(1, 0, 1, 1, 0, 3, 0, 0);
    add(6, 0, 1, 1, 0, 3, 0, 0);
    add(1, 0, 1, 1, 1, 4, 0, 1);
    add(3, 0, 1, 1, 0, 4, 0, 1);
    add(2, 0, 1, 0, 0, 4, 0, 1);   // lock drop in flight
    add(1, 0, 0, 0, 0, 0, 1, 0);   // disable coincides with lock loss -> IDLE
    add(3, 0, 0, 0, 0, 0, 1, 0);
    add(1, 0, 1, 1, 0, 1, 1, 0);   // glitch test start
    add(4, 0, 1, 1, 0, 1, 1, 0);
    add(1, 0, 1, 0, 0, 1, 1, 0);   // one-cycle lock low at count 5
    add(1, 0, 1, 1, 0, 1, 1, 0);
    add(8, 0, 1, 1, 0, 1, 1, 0);   // count restarted
    add(1, 0, 1, 1, 0, 2, 1, 0);   // RST_HOLD six cycles late
    add(1, 1, 1, 1, 0, 0, 1, 0);   // reset during RST_HOLD
    add(1, 0, 1, 1, 0, 1, 1, 0);
    add(8, 0, 1, 1, 0, 1, 1, 0);
    add(1, 0, 1, 1, 0, 2, 1, 0);
    add(3, 0, 1, 1, 0, 2, 1, 0);
    add(1, 0, 1, 1, 0, 3, 0, 0);
    add(6, 0, 1, 1, 0, 3, 0, 0);
    add(1, 0, 1, 1, 1, 4, 0, 1);
    add(2, 0, 1, 1, 0, 4, 0, 1);
    add(1, 1, 1, 1, 0, 0, 1, 0);   // reset during ACTIVE
    add(2, 0, 0, 0, 0, 0, 1, 0);

    for (int i = 0; i < vq.size(); i++) begin
      rst               = vq[i].rst;
      lif.i_enable      = vq[i].en;
      lif.i_mmcm_locked = vq[i].lock;
      lif.i_frame_start = vq[i].fs;
      for (int k = 0; k < vq[i].n; k++) begin
        tick();
        lif.i_frame_start = 1'b0;
      end
      check(i, vq[i].st, vq[i].ro, vq[i].lu);
    end

    // Bring-up timing from reset with enable and lock raised together.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    lif.i_enable = 1'b1;
    lif.i_mmcm_locked = 1'b1;
    edges = 0;
    while (edges < 100) begin
      tick();
      edges++;
      if (lif.o_rst_oserdes == 1'b0) break;
    end
    cmp("rst_fall_edge", 100, 10'(edges), 10'd14);

    // Early frame at SYNC cnt=3, then one 20 cycles later.
    tick();
    tick();
    tick();
    lif.i_frame_start = 1'b1;
    tick();
    lif.i_frame_start = 1'b0;
    check(101, 3'd3, 1'b0, 1'b0);
    for (int k = 0; k < 19; k++) tick();
    check(102, 3'd3, 1'b0, 1'b0);
    lif.i_frame_start = 1'b1;
    tick();
    lif.i_frame_start = 1'b0;
    check(103, 3'd4, 1'b0, 1'b1);
    tick();
    check(104, 3'd4, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
